ascon_enc_scheduler: RTL and testbench

- Round-robin job scheduler that shares one masked Ascon encryption core (3-share threshold implementation) among NREQ requesters.
- Per job, in order:
  - latches and holds the chosen request's operands;
  - requests a fresh mask set from the mask generator;
  - sequences the core's start/ready protocol, including the extra start pulse that returns the core from DONE to IDLE;
  - returns ciphertext and tag to the owning requester.
- A watchdog resets a hung core and returns an error response.

---
 rtl/ascon_enc_scheduler.sv | 164 ++++++++++++++++
 tb/tb_ascon_enc_scheduler.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ascon_enc_scheduler.sv
// Round-robin scheduler sharing one masked Ascon encryption core among NREQ requesters.
// Latches operands, fetches fresh masks, sequences start/ready, and aborts hung jobs via a watchdog.
module ascon_enc_scheduler #(
    parameter int unsigned NREQ    = 2,
    parameter int unsigned K       = 128,
    parameter int unsigned L       = 40,
    parameter int unsigned Y       = 40,
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*K-1:0]     req_key,
    input  logic [NREQ*128-1:0]   req_nonce,
    input  logic [NREQ*L-1:0]     req_ad,
    input  logic [NREQ*Y-1:0]     req_pt,
    output logic [NREQ-1:0]       resp_valid,
    input  logic [NREQ-1:0]       resp_ready,
    output logic [Y-1:0]          resp_ct,
    output logic [127:0]          resp_tag,
    output logic                  resp_err,
    output logic                  mask_req,
    input  logic                  mask_ack,
    output logic [K-1:0]          core_key,
    output logic [127:0]          core_nonce,
    output logic [L-1:0]          core_ad,
    output logic [Y-1:0]          core_pt,
    output logic                  core_start,
    input  logic                  core_ready,
    input  logic [Y-1:0]          core_ct,
    input  logic [127:0]          core_tag,
    output logic                  core_rst
);

    localparam int unsigned GW = $clog2(NREQ);
    localparam int unsigned WW = 10;

    typedef enum logic [2:0] {
        S_IDLE, S_MASK, S_START, S_BUSY, S_RELEASE, S_RESP, S_ABORT
    } state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   last_q, gnt_q, arb_idx;
    logic            arb_hit;
    logic [WW-1:0]   wd_q;
    logic            abort_q;
    logic [Y-1:0]    res_ct_q;
    logic [127:0]    res_tag_q;
    logic            res_err_q;

    logic [K-1:0]    key_arr   [NREQ];
    logic [127:0]    nonce_arr [NREQ];
    logic [L-1:0]    ad_arr    [NREQ];
    logic [Y-1:0]    pt_arr    [NREQ];

    // Per-requester views of the packed operand buses
    for (genvar i = 0; i < NREQ; i++) begin : g_slice
        assign key_arr[i]   = req_key[i*K +: K];
        assign nonce_arr[i] = req_nonce[i*128 +: 128];
        assign ad_arr[i]    = req_ad[i*L +: L];
        assign pt_arr[i]    = req_pt[i*Y +: Y];
    end

    // Round-robin search starting just after the last served requester
    always_comb begin
        arb_idx = last_q;
        arb_hit = 1'b0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            if (!arb_hit && req_valid[GW'((32'(last_q) + i) % NREQ)]) begin
                arb_hit = 1'b1;
                arb_idx = GW'((32'(last_q) + i) % NREQ);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        case (state_q)
            S_IDLE: begin
                if (arb_hit) begin
                    state_d   = S_MASK;
                    req_ready = rst ? (NREQ'(1) << arb_idx) : '0;
                end
            end
            S_MASK:    if (mask_ack) state_d = S_START;
            S_START:   state_d = S_BUSY;
            S_BUSY: begin
                if (core_ready)                 state_d = S_RELEASE;
                else if (wd_q == WW'(TIMEOUT))  state_d = S_ABORT;
            end
            S_RELEASE: state_d = S_RESP;
            S_ABORT:   if (abort_q) state_d = S_RESP;
            S_RESP:    if (resp_ready[gnt_q]) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Registered control and response outputs, decoded from the upcoming state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mask_req   <= 1'b0;
            core_start <= 1'b0;
            core_rst   <= 1'b0;
            resp_valid <= '0;
            resp_ct    <= '0;
            resp_tag   <= '0;
            resp_err   <= 1'b0;
        end else begin
            mask_req   <= (state_d == S_MASK);
            core_start <= (state_d == S_START) || (state_d == S_RELEASE);
            core_rst   <= (state_d == S_ABORT);
            resp_valid <= (state_d == S_RESP) ? (NREQ'(1) << gnt_q) : '0;
            resp_ct    <= (state_d == S_RESP) ? res_ct_q  : '0;
            resp_tag   <= (state_d == S_RESP) ? res_tag_q : '0;
            resp_err   <= (state_d == S_RESP) ? res_err_q : 1'b0;
        end
    end

    // Operands, results, watchdog and round-robin pointer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q     <= GW'(NREQ - 1);
            gnt_q      <= '0;
            wd_q       <= '0;
            abort_q    <= 1'b0;
            core_key   <= '0;
            core_nonce <= '0;
            core_ad    <= '0;
            core_pt    <= '0;
            res_ct_q   <= '0;
            res_tag_q  <= '0;
            res_err_q  <= 1'b0;
        end else begin
            if (state_q == S_IDLE && arb_hit) begin
                gnt_q      <= arb_idx;
                core_key   <= key_arr[arb_idx];
                core_nonce <= nonce_arr[arb_idx];
                core_ad    <= ad_arr[arb_idx];
                core_pt    <= pt_arr[arb_idx];
            end
            if (state_q == S_START)     wd_q <= '0;
            else if (state_q == S_BUSY) wd_q <= wd_q + WW'(1);
            abort_q <= (state_q == S_ABORT) ? ~abort_q : 1'b0;
            if (state_q == S_BUSY && core_ready) begin
                res_ct_q  <= core_ct;
                res_tag_q <= core_tag;
                res_err_q <= 1'b0;
            end else if (state_q == S_ABORT) begin
                res_ct_q  <= '0;
                res_tag_q <= '0;
                res_err_q <= 1'b1;
            end
            if (state_q == S_RESP && resp_ready[gnt_q]) last_q <= gnt_q;
        end
    end

endmodule

// File: tb/tb_ascon_enc_scheduler.sv
// Directed bench for ascon_enc_scheduler: grants, mask stall, watchdog abort, backpressure, reset.
// TIMEOUT is set to 15, so completing jobs keep the core's ready within 16 BUSY cycles.
module tb_ascon_enc_scheduler;

    localparam int unsigned NREQ    = 2;
    localparam int unsigned K       = 128;
    localparam int unsigned L       = 40;
    localparam int unsigned Y       = 40;
    localparam int unsigned TIMEOUT = 15;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic [NREQ-1:0]      req_valid = '0;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*K-1:0]    req_key;
    logic [NREQ*128-1:0]  req_nonce;
    logic [NREQ*L-1:0]    req_ad;
    logic [NREQ*Y-1:0]    req_pt;
    logic [NREQ-1:0]      resp_valid;
    logic [NREQ-1:0]      resp_ready = '0;
    logic [Y-1:0]         resp_ct;
    logic [127:0]         resp_tag;
    logic                 resp_err;
    logic                 mask_req;
    logic                 mask_ack = 1'b0;
    logic [K-1:0]         core_key;
    logic [127:0]         core_nonce;
    logic [L-1:0]         core_ad;
    logic [Y-1:0]         core_pt;
    logic                 core_start;
    logic                 core_ready = 1'b0;
    logic [Y-1:0]         core_ct = '0;
    logic [127:0]         core_tag = '0;
    logic                 core_rst;

    logic [K-1:0]   key_v   [NREQ];
    logic [127:0]   nonce_v [NREQ];
    logic [L-1:0]   ad_v    [NREQ];
    logic [Y-1:0]   pt_v    [NREQ];

    assign req_key   = {key_v[1], key_v[0]};
    assign req_nonce = {nonce_v[1], nonce_v[0]};
    assign req_ad    = {ad_v[1], ad_v[0]};
    assign req_pt    = {pt_v[1], pt_v[0]};

    ascon_enc_scheduler #(
        .NREQ(NREQ), .K(K), .L(L), .Y(Y), .TIMEOUT(TIMEOUT)
    ) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_key(req_key), .req_nonce(req_nonce), .req_ad(req_ad), .req_pt(req_pt),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_ct(resp_ct), .resp_tag(resp_tag), .resp_err(resp_err),
        .mask_req(mask_req), .mask_ack(mask_ack),
        .core_key(core_key), .core_nonce(core_nonce), .core_ad(core_ad), .core_pt(core_pt),
        .core_start(core_start), .core_ready(core_ready),
        .core_ct(core_ct), .core_tag(core_tag), .core_rst(core_rst)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int start_cnt = 0;
    int consec_cnt = 0;
    int overlap_cnt = 0;
    logic prev_start = 1'b0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    function automatic logic [NREQ-1:0] oh(input int i);
        return 2'(1) << i;
    endfunction

    // Protocol monitor on core_start pulses
    always @(negedge clk) begin
        if (core_start && prev_start) consec_cnt <= consec_cnt + 1;
        if (core_start && core_rst)   overlap_cnt <= overlap_cnt + 1;
        if (core_start)               start_cnt <= start_cnt + 1;
        prev_start <= core_start;
    end

    // One job from IDLE grant to response handshake; entered at a negedge in IDLE
    task automatic do_job(input int g, input int mask_wait, input int busy, input bit ready,
                          input int bp, input bit probe,
                          input logic [Y-1:0] ct, input logic [127:0] tag);
        int s0;
        bit ok;
        int o;
        logic [Y-1:0]   exp_ct;
        logic [127:0]   exp_tag;
        o       = 1 - g;
        exp_ct  = ready ? ct : '0;
        exp_tag = ready ? tag : '0;
        #1;
        check("req_ready_grant", 128'(req_ready), 128'(oh(g)));
        s0 = start_cnt;
        @(negedge clk);
        check("req_ready_pulse", 128'(req_ready), 128'(0));
        check("core_key", 128'(core_key), 128'(key_v[g]));
        check("core_nonce", core_nonce, nonce_v[g]);
        check("core_ad", 128'(core_ad), 128'(ad_v[g]));
        check("core_pt", 128'(core_pt), 128'(pt_v[g]));
        ok = 1'b1;
        for (int i = 0; i < mask_wait; i++) begin
            if (!(mask_req === 1'b1 && core_start === 1'b0)) ok = 1'b0;
            if (i == mask_wait - 1) mask_ack = 1'b1;
            @(negedge clk);
        end
        mask_ack = 1'b0;
        check("mask_req_held", 128'(ok), 128'(1));
        check("start_pulse", 128'(core_start), 128'(1));
        check("mask_req_drop", 128'(mask_req), 128'(0));
        @(negedge clk);
        ok = 1'b1;
        for (int b = 1; b <= busy; b++) begin
            if (!(core_start === 1'b0 && core_rst === 1'b0)) ok = 1'b0;
            if (b == busy && ready) begin
                core_ready = 1'b1;
                core_ct    = ct;
                core_tag   = tag;
            end
            @(negedge clk);
        end
        core_ready = 1'b0;
        core_ct    = ~ct;
        core_tag   = ~tag;
        check("busy_quiet", 128'(ok), 128'(1));
        if (ready) begin
            check("release_start", 128'(core_start), 128'(1));
            check("release_no_resp", 128'(resp_valid), 128'(0));
            @(negedge clk);
        end else begin
            check("abort_rst1", 128'(core_rst), 128'(1));
            check("abort_no_start", 128'(core_start), 128'(0));
            @(negedge clk);
            check("abort_rst2", 128'(core_rst), 128'(1));
            @(negedge clk);
        end
        check("resp_valid", 128'(resp_valid), 128'(oh(g)));
        check("resp_core_rst", 128'(core_rst), 128'(0));
        check("resp_ct", 128'(resp_ct), 128'(exp_ct));
        check("resp_tag", resp_tag, exp_tag);
        check("resp_err", 128'(resp_err), 128'(!ready));
        check("start_pulses", 128'(start_cnt - s0), ready ? 128'(2) : 128'(1));
        check("operands_held", 128'(core_key), 128'(key_v[g]));
        ok = 1'b1;
        for (int i = 0; i < bp; i++) begin
            if (probe) begin
                req_valid  = req_valid | oh(o);
                resp_ready = oh(o);
                #1;
                if (req_ready !== '0) ok = 1'b0;
            end
            @(negedge clk);
            if (resp_valid !== oh(g) || resp_ct !== exp_ct || resp_tag !== exp_tag) ok = 1'b0;
        end
        if (bp > 0) check("bp_stable", 128'(ok), 128'(1));
        resp_ready = oh(g);
        @(negedge clk);
        resp_ready = '0;
        check("resp_drop", 128'(resp_valid), 128'(0));
        check("ct_zero_idle", 128'(resp_ct), 128'(0));
        check("tag_zero_idle", resp_tag, 128'(0));
        if (probe) begin
            #1;
            check("probe_grant", 128'(req_ready), 128'(oh(o)));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not reach the end");
        $fatal(1, "global timeout");
    end

    initial begin
        key_v[0]   = 128'h000102030405060708090a0b0c0d0e0f;
        nonce_v[0] = 128'h000102030405060708090a0b0c0d0e0f;
        ad_v[0]    = 40'h0001020304;
        pt_v[0]    = 40'h0001020304;
        key_v[1]   = 128'h1f1e1d1c1b1a19181716151413121110;
        nonce_v[1] = 128'hdeadbeef0123456789abcdef55aa33cc;
        ad_v[1]    = 40'h1112131415;
        pt_v[1]    = 40'h2122232425;

        // Reset state, including suppression of req_ready while reset is held
        repeat (3) @(negedge clk);
        req_valid = 2'b11;
        #1;
        check("rst_req_ready", 128'(req_ready), 128'(0));
        check("rst_resp_valid", 128'(resp_valid), 128'(0));
        check("rst_mask_req", 128'(mask_req), 128'(0));
        check("rst_core_start", 128'(core_start), 128'(0));
        check("rst_core_rst", 128'(core_rst), 128'(0));
        check("rst_core_key", 128'(core_key), 128'(0));
        check("rst_resp_tag", resp_tag, 128'(0));
        rst = 1'b1;

        // Fairness with both requesters always pending
        do_job(0, 1, 8, 1'b1, 0, 1'b0, 40'h1111111111, 128'ha0);
        do_job(1, 1, 8, 1'b1, 0, 1'b0, 40'h2222222222, 128'hb1);
        do_job(0, 1, 8, 1'b1, 0, 1'b0, 40'h3333333333, 128'hc2);
        do_job(1, 1, 8, 1'b1, 0, 1'b0, 40'h4444444444, 128'hd3);

        // Single job from requester 0, ack one cycle after mask_req
        req_valid = 2'b01;
        do_job(0, 2, 8, 1'b1, 0, 1'b0, 40'hc0ffee1234, 128'h0123456789abcdeffedcba9876543210);

        // Mask stall: ack withheld for 20 cycles
        req_valid = 2'b10;
        do_job(1, 21, 8, 1'b1, 0, 1'b0, 40'h5a5a5a5a5a, 128'h77);

        // Watchdog abort, then a normal job
        req_valid = 2'b01;
        do_job(0, 1, 16, 1'b0, 0, 1'b0, 40'h0, 128'h0);
        req_valid = 2'b10;
        do_job(1, 1, 5, 1'b1, 0, 1'b0, 40'h9876543210, 128'h55);

        // Ready in the same cycle the watchdog expires wins
        req_valid = 2'b01;
        do_job(0, 1, 16, 1'b1, 0, 1'b0, 40'habcdef0123, 128'h99);

        // Backpressure with a competing request and a foreign resp_ready
        req_valid = 2'b01;
        do_job(0, 1, 4, 1'b1, 10, 1'b1, 40'h0f0f0f0f0f, 128'hf00d);
        req_valid = 2'b10;
        do_job(1, 1, 3, 1'b1, 0, 1'b0, 40'h1234512345, 128'hbeef);
        req_valid = 2'b01;
        do_job(0, 1, 3, 1'b1, 0, 1'b0, 40'h6666666666, 128'h66);

        // Reset in the middle of a BUSY job for requester 1
        req_valid = 2'b10;
        #1;
        check("mid_grant", 128'(req_ready), 128'(2'b10));
        @(negedge clk);
        mask_ack = 1'b1;
        @(negedge clk);
        mask_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        req_valid = 2'b11;
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_core_start", 128'(core_start), 128'(0));
        check("mid_rst_mask_req", 128'(mask_req), 128'(0));
        check("mid_rst_req_ready", 128'(req_ready), 128'(0));
        check("mid_rst_core_key", 128'(core_key), 128'(0));
        check("mid_rst_core_nonce", core_nonce, 128'(0));
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("post_rst_grant", 128'(req_ready), 128'(2'b01));
        req_valid = 2'b01;
        do_job(0, 1, 6, 1'b1, 0, 1'b0, 40'h7777777777, 128'h88);
        req_valid = 2'b00;

        repeat (2) @(negedge clk);
        check("start_consecutive", 128'(consec_cnt), 128'(0));
        check("start_during_rst", 128'(overlap_cnt), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
